// File: rtl/lcg_stim_pkg.sv
// Shared types and helpers for the LCG stimulus generator.
// LCG_STIM_MISR_EN enables response folding into a MISR signature.
package lcg_stim_pkg;
    localparam logic [31:0] LCG_MULT  = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC   = 32'h00003039;
    localparam logic [31:0] MISR_TAPS = 32'h80200003;
    localparam int          FOLD_MAX  = 1024;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [31:0] lcg_step(
        input logic [31:0] s,
        input logic [31:0] m,
        input logic [31:0] i
    );
        return s * m + i;
    endfunction

    // Callers zero-extend narrower buses to FOLD_MAX bits.
    function automatic logic [31:0] fold32(input logic [FOLD_MAX-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int k = 0; k < FOLD_MAX / 32; k++)
            f ^= d[k*32 +: 32];
        return f;
    endfunction
endpackage

// File: rtl/lcg_stim_if.sv
// Stimulus and response handshake bundle between generator and DUT side.
// Master drives stimulus; slave drives ready and responses.
interface lcg_stim_if #(
    parameter int STIM_W = 277,
    parameter int RESP_W = 330
);
    logic              stim_valid;
    logic              stim_ready;
    logic [STIM_W-1:0] stim_data;
    logic              resp_valid;
    logic [RESP_W-1:0] resp_data;

    modport master (
        output stim_valid, stim_data,
        input  stim_ready, resp_valid, resp_data
    );

    modport slave (
        input  stim_valid, stim_data,
        output stim_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/lcg_stim_gen_chain.sv
// Unrolled LCG chain: lane k holds the (k+1)-th step from s_in.
// Purely combinational; s_out is the last lane's state.
module lcg_lane_chain
    import lcg_stim_pkg::*;
#(
    parameter int          LANES = 9,
    parameter logic [31:0] MULT  = LCG_MULT,
    parameter logic [31:0] INC   = LCG_INC
) (
    input  logic [31:0]         s_in,
    output logic [32*LANES-1:0] lanes,
    output logic [31:0]         s_out
);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] nxt;
        if (k == 0) begin : g_first
            assign nxt = lcg_step(s_in, MULT, INC);
        end else begin : g_rest
            assign nxt = lcg_step(g_lane[k-1].nxt, MULT, INC);
        end
        assign lanes[k*32 +: 32] = nxt;
    end

    assign s_out = g_lane[LANES-1].nxt;
endmodule

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator: seeded vector stream with valid/ready and count.
// Define LCG_STIM_MISR_EN to fold responses into a MISR signature.
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int          STIM_W = 277,
    parameter int          RESP_W = 330,
    parameter logic [31:0] MULT   = LCG_MULT,
    parameter logic [31:0] INC    = LCG_INC,
    parameter int          CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    lcg_stim_if.master       bus,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature
);
    localparam int LANES = (STIM_W + 31) / 32;

    state_t              state;
    logic [31:0]         lcg;
    logic [CNT_W-1:0]    nv_q;
    logic [31:0]         s_in;
    logic [32*LANES-1:0] lanes;
    logic [31:0]         s_out;

    // One chain serves both the restart vector and the follow-on vectors.
    assign s_in = start ? seed : lcg;

    lcg_lane_chain #(
        .LANES (LANES),
        .MULT  (MULT),
        .INC   (INC)
    ) u_chain (
        .s_in  (s_in),
        .lanes (lanes),
        .s_out (s_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            lcg            <= '0;
            nv_q           <= '0;
            bus.stim_valid <= 1'b0;
            bus.stim_data  <= '0;
            vec_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (start) begin
            state          <= RUN;
            lcg            <= s_out;
            nv_q           <= num_vec;
            bus.stim_valid <= 1'b1;
            bus.stim_data  <= lanes[STIM_W-1:0];
            vec_cnt        <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
        end else if (state == RUN && bus.stim_valid && bus.stim_ready) begin
            if (vec_cnt == nv_q) begin
                state          <= DONE;
                bus.stim_valid <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
            end else begin
                lcg           <= s_out;
                bus.stim_data <= lanes[STIM_W-1:0];
                if (vec_cnt != '1)
                    vec_cnt <= vec_cnt + 1'b1;
            end
        end
    end

`ifdef LCG_STIM_MISR_EN
    logic [31:0] sig;

    always_ff @(posedge clk) begin
        if (rst || start)
            sig <= '0;
        else if (bus.resp_valid && state != IDLE)
            sig <= {sig[30:0], ^(sig & MISR_TAPS)}
                 ^ fold32(FOLD_MAX'(bus.resp_data));
    end

    assign signature = sig;
`else
    logic unused_resp;
    assign unused_resp = ^{bus.resp_valid, bus.resp_data};
    assign signature   = '0;
`endif
endmodule
